// File: rtl/alu_sched.sv
// Shared-ALU scheduler: arbitrates two requesters onto one external combinational ALU
// and repeats a single op cnt times with the accumulator fed back as reg0.
module alu_sched #(
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,

    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [3:0]       i_req0_op,
    input  logic [1:0]       i_req0_fmt,
    input  logic [31:0]      i_req0_a,
    input  logic [31:0]      i_req0_b,
    input  logic [CNT_W-1:0] i_req0_cnt,

    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [3:0]       i_req1_op,
    input  logic [1:0]       i_req1_fmt,
    input  logic [31:0]      i_req1_a,
    input  logic [31:0]      i_req1_b,
    input  logic [CNT_W-1:0] i_req1_cnt,

    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic [31:0]      o_rsp_data,
    input  logic             i_rsp_ready,

    output logic [31:0]      o_alu_reg0,
    output logic [31:0]      o_alu_reg1,
    output logic [3:0]       o_alu_do,
    output logic [1:0]       o_alu_fmt,
    input  logic [31:0]      i_alu_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic               prio_q, prio_d;
    logic [31:0]        acc_q, acc_d;
    logic [31:0]        b_q, b_d;
    logic [3:0]         op_q, op_d;
    logic [1:0]         fmt_q, fmt_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               id_q, id_d;

    logic               any_valid;
    logic               grant_id;
    logic               accept;
    logic [CNT_W-1:0]   sel_cnt;

    // With both valid the priority bit decides; otherwise whoever is valid wins.
    // Readys are gated by reset so nothing is seen as accepted during reset.
    assign any_valid    = i_req0_valid | i_req1_valid;
    assign grant_id     = (i_req0_valid & i_req1_valid) ? prio_q : i_req1_valid;
    assign accept       = (state_q == S_IDLE) & any_valid & ~i_rst;
    assign o_req0_ready = accept & ~grant_id;
    assign o_req1_ready = accept & grant_id;
    assign sel_cnt      = grant_id ? i_req1_cnt : i_req0_cnt;

    assign o_rsp_valid  = (state_q == S_DONE);
    assign o_rsp_id     = id_q;
    assign o_rsp_data   = acc_q;

    assign o_alu_reg0   = acc_q;
    assign o_alu_reg1   = b_q;
    assign o_alu_do     = op_q;
    assign o_alu_fmt    = fmt_q;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no branch can infer a latch.
        state_d = state_q;
        prio_d  = prio_q;
        acc_d   = acc_q;
        b_d     = b_q;
        op_d    = op_q;
        fmt_d   = fmt_q;
        rem_d   = rem_q;
        id_d    = id_q;

        unique case (state_q)
            S_IDLE: begin
                if (any_valid) begin
                    op_d    = grant_id ? i_req1_op  : i_req0_op;
                    fmt_d   = grant_id ? i_req1_fmt : i_req0_fmt;
                    acc_d   = grant_id ? i_req1_a   : i_req0_a;
                    b_d     = grant_id ? i_req1_b   : i_req0_b;
                    rem_d   = sel_cnt;
                    id_d    = grant_id;
                    prio_d  = ~grant_id;
                    state_d = (sel_cnt == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // rem is at least 1 here, so the decrement cannot wrap.
                acc_d = i_alu_out;
                rem_d = rem_q - CNT_W'(1);
                if (rem_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (i_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
        if (i_rst) begin
            state_q <= S_IDLE;
            prio_q  <= 1'b0;
            acc_q   <= '0;
            b_q     <= '0;
            op_q    <= '0;
            fmt_q   <= '0;
            rem_q   <= '0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            op_q    <= op_d;
            fmt_q   <= fmt_d;
            rem_q   <= rem_d;
            id_q    <= id_d;
        end
    end

endmodule
